// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizing for the gcd host driver
package gcd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND_A, SEND_B, WAIT, RESP} gcd_drv_state_t;
  localparam int GCD_WIDTH = 8;
  localparam int GCD_TIMEOUT = 255;
endpackage

// File: rtl/gcd_host_driver_rise_detect.sv
// rise_detect: registers d and flags a fresh rising edge as d & ~d_q
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/gcd_host_driver.sv
// gcd_host_driver: sequences load/A/B onto gcd_thread, waits for a fresh done rise or timeout, returns the result
module gcd_host_driver
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_timeout,
  output logic             gcd_load,
  output logic [WIDTH-1:0] gcd_val_in,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_val_out
);
  localparam int CW = $clog2(TIMEOUT + 1);
  gcd_drv_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rsp_gcd_q, rsp_gcd_d, val_in_q, val_in_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_timeout_q, rsp_timeout_d, load_q, load_d, ready_q, ready_d, valid_q, valid_d;
  logic done_rise;
  rise_detect u_done_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gcd_done),
    .rise (done_rise)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        state_d = LOAD;
        a_d = req_a;
        b_d = req_b;
      end
      LOAD: state_d = SEND_A;
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = WAIT;
      WAIT: if (done_rise) begin
        state_d = RESP;
        rsp_gcd_d = gcd_val_out;
        rsp_timeout_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = RESP;
        rsp_gcd_d = '0;
        rsp_timeout_d = 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_d = state_d == LOAD;
    val_in_d = state_d == SEND_A ? a_q : state_d == SEND_B ? b_q : '0;
    ready_d = state_d == IDLE;
    valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      rsp_gcd_q <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q <= '0;
      load_q <= 1'b0;
      val_in_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      rsp_gcd_q <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q <= cnt_d;
      load_q <= load_d;
      val_in_q <= val_in_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_gcd = rsp_gcd_q;
  assign rsp_timeout = rsp_timeout_q;
  assign gcd_load = load_q;
  assign gcd_val_in = val_in_q;
endmodule

// File: tb/tb_gcd_host_driver.sv
// tb_gcd_host_driver: scoreboard bench pairing the driver with a behavioural gcd_thread
module tb_gcd_host_driver;
  localparam int W = 8;
  localparam int TO = 16;
  typedef struct packed {
    logic [W-1:0] g;
    logic t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0, stub = 1'b0, hold = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_timeout, gcd_load, gcd_done;
  logic [W-1:0] rsp_gcd, gcd_val_in, gcd_val_out;
  logic m_done = 1'b0;
  logic [W-1:0] m_out = '0, m_a = '0, m_b = '0;
  int m_ph = 0, m_cnt = 0, n_chk = 0, n_fail = 0;
  exp_t sb[$];
  exp_t m_e;
  gcd_host_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_timeout(rsp_timeout),
    .gcd_load   (gcd_load),
    .gcd_val_in (gcd_val_in),
    .gcd_done   (gcd_done),
    .gcd_val_out(gcd_val_out)
  );
  assign gcd_done = stub ? 1'b0 : m_done;
  assign gcd_val_out = m_out;
  always #5 clk = ~clk;
  function automatic logic [W-1:0] gcd_calc(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction
  always @(posedge clk)
    if (!rst_n) m_ph <= 0;
    else if (gcd_load) begin
      m_ph <= 1;
      if (!hold) m_done <= 1'b0;
    end else if (m_ph == 1) begin
      m_a <= gcd_val_in;
      m_ph <= 2;
    end else if (m_ph == 2) begin
      m_b <= gcd_val_in;
      m_ph <= 3;
      m_cnt <= 0;
    end else if (m_ph == 3) begin
      m_cnt <= m_cnt + 1;
      if (hold && m_cnt == 2) m_done <= 1'b0;
      if (m_cnt == (hold ? 5 : 2)) begin
        m_done <= 1'b1;
        m_out <= gcd_calc(m_a, m_b);
        m_ph <= 0;
      end
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      check("ready_valid_excl", {31'd0, req_ready & rsp_valid}, 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          m_e = sb.pop_front();
          check("rsp_gcd", rsp_gcd, m_e.g);
          check("rsp_timeout", rsp_timeout, m_e.t);
        end
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                        input logic t, input bit push);
    int k = 0;
    while (!req_ready && k < 100) begin
      step();
      k++;
    end
    if (k == 100) check("req_ready_wait", 0, 1);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    if (push) sb.push_back('{g, t});
    step();
    req_valid = 1'b0;
    check("load_hi", gcd_load, 1);
    check("val_in_load", gcd_val_in, 0);
    check("req_ready_load", req_ready, 0);
    step();
    check("load_lo", gcd_load, 0);
    check("val_in_a", gcd_val_in, a);
    step();
    check("val_in_b", gcd_val_in, b);
    check("req_ready_send", req_ready, 0);
    step();
    check("val_in_wait", gcd_val_in, 0);
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || !req_ready) && k < 200) begin
      step();
      k++;
    end
    if (k == 200) check("idle_wait", 0, 1);
  endtask
  task automatic check_reset_outs();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_gcd", rsp_gcd, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_gcd_load", gcd_load, 0);
    check("rst_val_in", gcd_val_in, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    #1 rst_n = 1'b0;
    #2 check_reset_outs();
    @(negedge clk) rst_n = 1'b1;
    step();
    rsp_ready = 1'b1;
    do_req(8, 20, 4, 1'b0, 1);
    wait_idle();
    do_req(18, 45, 9, 1'b0, 1);
    do_req(28, 49, 7, 1'b0, 1);
    wait_idle();
    stub = 1'b1;
    do_req(5, 10, 0, 1'b1, 1);
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i == TO - 1) check("to_not_early", rsp_valid, 0);
      if (i == TO) check("to_valid", rsp_valid, 1);
    end
    wait_idle();
    stub = 1'b0;
    step();
    rsp_ready = 1'b0;
    do_req(18, 45, 9, 1'b0, 1);
    k = 0;
    while (!rsp_valid && k < 100) begin
      step();
      k++;
    end
    if (k == 100) check("rsp_valid_wait", 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_gcd", rsp_gcd, 9);
      check("hold_req_ready", req_ready, 0);
      req_a = 8'd1;
      req_b = 8'd1;
      req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("idle_after_hs", req_ready, 1);
    check("valid_after_hs", rsp_valid, 0);
    hold = 1'b1;
    do_req(28, 49, 7, 1'b0, 1);
    wait_idle();
    hold = 1'b0;
    req_a = 8'd3;
    req_b = 8'd6;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("load_before_rst", gcd_load, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs();
    #1 rst_n = 1'b1;
    step();
    do_req(18, 45, 0, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("no_rsp_after_rst", rsp_valid, 0);
    do_req(8, 20, 4, 1'b0, 1);
    wait_idle();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
